stage2_add_ctrl: RTL and testbench



---
 rtl/lenet5_pkg.sv | 17 +
 rtl/bias_relu_sat.sv | 40 ++++
 rtl/stage2_add_ctrl.sv | 139 +++++++++++++
 tb/tb_stage2_add_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lenet5_pkg.sv
// Shared LeNet-5 datapath definitions.
//   C3_MAP_PIXELS      : output pixels in one C3 feature map (10x10)
//   STAGE2_ADD_LATENCY : fixed latency of the stage2_add adder tree
//   stage2_ctrl_state_t: sequencer states of stage2_add_ctrl
package lenet5_pkg;

  localparam int C3_MAP_PIXELS      = 100;
  localparam int STAGE2_ADD_LATENCY = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } stage2_ctrl_state_t;

endpackage

// File: rtl/bias_relu_sat.sv
// Combinational bias add with saturation and optional ReLU.
// The sum is formed one bit wider than the data, clamped back to the signed
// DATA_WIDTH range, then forced to zero when ReLU is on and it is negative.
// Ports:
//   sum_i     : signed adder-tree result
//   bias_i    : signed bias
//   relu_en_i : zero negative results when high
//   pix_o     : saturated, activated pixel
module bias_relu_sat #(
  parameter int DATA_WIDTH = 16
) (
  input  logic signed [DATA_WIDTH-1:0] sum_i,
  input  logic signed [DATA_WIDTH-1:0] bias_i,
  input  logic                         relu_en_i,
  output logic signed [DATA_WIDTH-1:0] pix_o
);

  // Overflow shows up as the two top bits of the widened sum disagreeing;
  // the top bit then carries the true sign and picks the clamp rail.
  function automatic logic signed [DATA_WIDTH-1:0] sat(
    input logic signed [DATA_WIDTH:0] s
  );
    if (s[DATA_WIDTH] != s[DATA_WIDTH-1]) begin
      sat = s[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                          : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end else begin
      sat = s[DATA_WIDTH-1:0];
    end
  endfunction

  logic signed [DATA_WIDTH:0]   wide;
  logic signed [DATA_WIDTH-1:0] clamped;

  always_comb begin
    wide    = {sum_i[DATA_WIDTH-1], sum_i} + {bias_i[DATA_WIDTH-1], bias_i};
    clamped = sat(wide);
    pix_o   = (relu_en_i && clamped[DATA_WIDTH-1]) ? '0 : clamped;
  end

endmodule

// File: rtl/stage2_add_ctrl.sv
// Sequencer for the six-input, three-cycle stage2_add channel adder tree in
// the LeNet-5 C3 path. Feeds one 6-channel word per output pixel into the
// adder, tracks the adder latency with a valid shift register, then adds the
// map bias with saturation and optional ReLU, and flags end-of-map.
// Ports:
//   clk, rst_n              : clock, synchronous active-low reset
//   start, bias, relu_en    : begin a map (sampled in IDLE), latched settings
//   in_valid/in_ready/in_data : upstream 6-channel words (channel a in LSBs)
//   add_en, add_data        : adder enable and operands (registered)
//   add_dataout             : adder result
//   out_valid/out_data/out_last : pixel stream to S4, no backpressure
//   busy, done              : not-IDLE flag, one-cycle end-of-map pulse
module stage2_add_ctrl
  import lenet5_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int MAP_PIXELS  = C3_MAP_PIXELS,
  parameter int ADD_LATENCY = STAGE2_ADD_LATENCY
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [DATA_WIDTH-1:0]   bias,
  input  logic                    relu_en,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [6*DATA_WIDTH-1:0] in_data,
  output logic                    add_en,
  output logic [6*DATA_WIDTH-1:0] add_data,
  input  logic [DATA_WIDTH-1:0]   add_dataout,
  output logic                    out_valid,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    out_last,
  output logic                    busy,
  output logic                    done
);

  localparam int              CW       = $clog2(MAP_PIXELS + 1);
  localparam logic [CW-1:0]   LAST_IDX = CW'(MAP_PIXELS - 1);

  stage2_ctrl_state_t state_q, state_d;

  logic signed [DATA_WIDTH-1:0] bias_q;
  logic                         relu_q;
  logic [CW-1:0]                in_cnt_q, out_cnt_q;
  logic [6*DATA_WIDTH-1:0]      add_data_q;
  logic                         add_vld_q;
  logic [ADD_LATENCY-1:0]       vpipe_q;
  logic                         out_valid_q, out_last_q;
  logic signed [DATA_WIDTH-1:0] out_data_q;
  logic signed [DATA_WIDTH-1:0] pix;
  logic                         accept;

  bias_relu_sat #(.DATA_WIDTH(DATA_WIDTH)) u_bias_relu_sat (
    .sum_i     (add_dataout),
    .bias_i    (bias_q),
    .relu_en_i (relu_q),
    .pix_o     (pix)
  );

  assign accept = in_valid && in_ready;

  // add_en stays high through FLUSH so the words still inside the adder are
  // not cleared; it only drops in IDLE/DONE, where vpipe is already empty.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    add_en   = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        in_ready = 1'b1;
        add_en   = 1'b1;
        if (accept && (in_cnt_q == LAST_IDX)) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        add_en = 1'b1;
        // Leave one cycle after the last pixel so done follows out_last.
        if (out_valid_q && out_last_q) state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      bias_q      <= '0;
      relu_q      <= 1'b0;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      add_data_q  <= '0;
      add_vld_q   <= 1'b0;
      vpipe_q     <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == ST_IDLE) && start) begin
        bias_q    <= bias;
        relu_q    <= relu_en;
        in_cnt_q  <= '0;
        out_cnt_q <= '0;
      end
      if (accept) in_cnt_q <= in_cnt_q + CW'(1);

      // Operand register: a refused/idle slot becomes a zero bubble.
      add_data_q <= accept ? in_data : '0;
      add_vld_q  <= accept;

      // Valid tracks the word through the adder's registers.
      vpipe_q <= {vpipe_q[ADD_LATENCY-2:0], add_vld_q};

      // Output stage
      out_valid_q <= vpipe_q[ADD_LATENCY-1];
      out_last_q  <= vpipe_q[ADD_LATENCY-1] && (out_cnt_q == LAST_IDX);
      if (vpipe_q[ADD_LATENCY-1]) begin
        out_data_q <= pix;
        out_cnt_q  <= out_cnt_q + CW'(1);
      end
    end
  end

  assign add_data  = add_data_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_stage2_add_ctrl.sv
// Bench for stage2_add_ctrl: a behavioural stage2_add sits beside the DUT,
// and a queue-based reference model predicts every pixel and its cycle.
module tb_stage2_add_ctrl;

  localparam int DW = 16;
  localparam int MP = 100;

  logic          clk, rst_n, start, relu_en, in_valid;
  logic [DW-1:0] bias;
  logic [6*DW-1:0] in_data;
  logic          in_ready, add_en, out_valid, out_last, busy, done;
  logic [6*DW-1:0] add_data;
  logic [DW-1:0] add_dataout, out_data;

  stage2_add_ctrl #(.DATA_WIDTH(DW), .MAP_PIXELS(MP), .ADD_LATENCY(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bias(bias), .relu_en(relu_en),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .add_en(add_en), .add_data(add_data), .add_dataout(add_dataout),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural stage2_add: three registers, en=0 clears them.
  function automatic logic [DW-1:0] sum6(input logic [6*DW-1:0] w);
    logic [DW-1:0] s;
    s = '0;
    for (int k = 0; k < 6; k++) s = s + w[k*DW +: DW];
    return s;
  endfunction

  logic [DW-1:0] a1, a2, a3;
  always @(posedge clk) begin
    if (!add_en) begin
      a1 <= '0; a2 <= '0; a3 <= '0;
    end else begin
      a1 <= sum6(add_data); a2 <= a1; a3 <= a2;
    end
  end
  assign add_dataout = a3;

  // Reference model
  typedef struct { logic [DW-1:0] v; int due; } exp_t;
  exp_t q[$];
  int  n_cmp, n_err;
  int  cyc, n_acc, out_idx, last_cyc, bias_m, n_starts, dut_ov_cnt;
  bit  idle_m, relu_m, last_acc, prev_acc;
  logic [6*DW-1:0] prev_word;

  function automatic logic [DW-1:0] ref_pix(input logic [6*DW-1:0] w,
                                            input int b, input bit r);
    int s;
    logic signed [DW-1:0] t;
    t = sum6(w);
    s = int'(t) + b;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    if (r && s < 0) s = 0;
    return s[DW-1:0];
  endfunction

  task automatic chk(input string tag, input logic [6*DW-1:0] obs,
                     input logic [6*DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    bit e_busy, e_done, e_en, e_rdy, e_ov, e_last, acc, take, fin;
    @(negedge clk);
    e_busy = !idle_m;
    e_done = !idle_m && last_cyc >= 0 && cyc == last_cyc + 1;
    e_en   = !idle_m && !e_done;
    e_rdy  = !idle_m && n_acc < MP;
    e_ov   = q.size() > 0 && q[0].due == cyc;
    e_last = e_ov && out_idx == MP - 1;
    chk("busy", busy, e_busy);
    chk("done", done, e_done);
    chk("add_en", add_en, e_en);
    chk("in_ready", in_ready, e_rdy);
    chk("out_valid", out_valid, e_ov);
    chk("out_last", out_last, e_last);
    chk("add_data", add_data, prev_acc ? prev_word : '0);
    if (out_valid) dut_ov_cnt++;
    if (e_ov) begin
      chk("out_data", out_data, q[0].v);
      if (e_last) last_cyc = cyc;
      void'(q.pop_front());
      out_idx++;
    end
    acc  = rst_n && e_rdy && in_valid;
    take = rst_n && idle_m && start;
    fin  = e_done;
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      idle_m = 1'b1; q.delete(); last_cyc = -1; acc = 1'b0;
    end else begin
      if (take) begin
        idle_m = 1'b0; n_acc = 0; out_idx = 0; last_cyc = -1;
        bias_m = int'($signed(bias)); relu_m = relu_en; n_starts++;
      end
      if (acc) begin
        q.push_back('{v: ref_pix(in_data, bias_m, relu_m), due: cyc + 4});
        n_acc++;
      end
      if (fin) idle_m = 1'b1;
    end
    prev_acc  = acc;
    prev_word = in_data;
    last_acc  = acc;
    #1;
  endtask

  task automatic start_map(input logic [DW-1:0] b, input bit r);
    start = 1'b1; bias = b; relu_en = r; dut_ov_cnt = 0;
    tick();
    start = 1'b0; bias = 16'(($urandom));
  endtask

  task automatic bubble(input int n);
    in_valid = 1'b0;
    for (int k = 0; k < n; k++) begin
      in_data = {$urandom, $urandom, $urandom};
      tick();
    end
  endtask

  task automatic drive_word(input logic [6*DW-1:0] w);
    in_valid = 1'b1; in_data = w; last_acc = 1'b0;
    for (int k = 0; k < 20 && !last_acc; k++) tick();
    if (!last_acc) begin
      n_err++; $display("FAIL accept_timeout: word %0h never accepted", w);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    in_valid = 1'b0;
    for (int k = 0; k < budget && !idle_m; k++) tick();
    if (!idle_m) begin
      n_err++; $display("FAIL idle_timeout: map still active after %0d cycles", budget);
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0; cyc = 0; n_acc = 0; out_idx = 0; last_cyc = -1;
    bias_m = 0; relu_m = 0; idle_m = 1; n_starts = 0; dut_ov_cnt = 0;
    prev_acc = 0; prev_word = '0; last_acc = 0;
    rst_n = 1'b0; start = 1'b0; bias = '0; relu_en = 1'b0;
    in_valid = 1'b0; in_data = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset values
    chk("rst in_ready", in_ready, 0);   chk("rst add_en", add_en, 0);
    chk("rst add_data", add_data, 0);   chk("rst out_valid", out_valid, 0);
    chk("rst out_data", out_data, 0);   chk("rst out_last", out_last, 0);
    chk("rst busy", busy, 0);           chk("rst done", done, 0);
    bubble(2);

    // Basic sum: 11, 17, 23, -55 then random words, no stalls
    start_map(16'd5, 1'b0);
    drive_word({6{16'd1}});  drive_word({6{16'd2}});
    drive_word({6{16'd3}});  drive_word({6{-16'sd10}});
    for (int i = 4; i < MP; i++) drive_word({$urandom, $urandom, $urandom});
    wait_idle(30);
    chk("map1 pulses", dut_ov_cnt, MP);
    bubble(1);

    // ReLU: sums -7 and 7
    start_map(16'd0, 1'b1);
    drive_word({-16'sd2, -16'sd1, -16'sd1, -16'sd1, -16'sd1, -16'sd1});
    drive_word({16'd2, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1});
    for (int i = 2; i < MP; i++) drive_word({$urandom, $urandom, $urandom});
    wait_idle(30);
    chk("map2 pulses", dut_ov_cnt, MP);

    // Positive saturation with random stalls
    start_map(16'd1, 1'b0);
    drive_word({80'd0, 16'h7FFF});
    for (int i = 1; i < MP; i++) begin
      bubble($urandom_range(0, 1));
      drive_word({$urandom, $urandom, $urandom});
    end
    wait_idle(30);
    chk("map3 pulses", dut_ov_cnt, MP);

    // Negative saturation, 1,0,0 valid pattern, start pulsed while busy
    start_map(16'hFFFF, 1'b0);
    drive_word({80'd0, 16'h8000});
    bubble(2);
    for (int i = 1; i < MP; i++) begin
      drive_word({$urandom, $urandom, $urandom});
      start = (i % 7 == 0); bias = 16'd77; relu_en = 1'b1;
      bubble(2);
      start = 1'b0;
    end
    chk("map4 busy before flush end", busy, 1);
    // Hold start through FLUSH/DONE: ignored until IDLE, then taken at once
    start = 1'b1; bias = 16'd77; relu_en = 1'b1;
    for (int k = 0; k < 30 && n_starts < 5; k++) tick();
    start = 1'b0;
    chk("map4 pulses", dut_ov_cnt, MP);
    chk("back-to-back start", busy, 1);
    dut_ov_cnt = 0;

    // Reset mid-map after 50 accepts
    for (int i = 0; i < 50; i++) drive_word({$urandom, $urandom, $urandom});
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst add_en", add_en, 0);
    chk("midrst busy", busy, 0);
    chk("midrst out_data", out_data, 0);
    chk("midrst add_data", add_data, 0);
    dut_ov_cnt = 0;
    bubble(8);
    chk("midrst no output", dut_ov_cnt, 0);

    // Full map after reset
    start_map(16'($urandom), 1'b0);
    for (int i = 0; i < MP; i++) begin
      bubble($urandom_range(0, 2));
      drive_word({$urandom, $urandom, $urandom});
    end
    wait_idle(30);
    chk("map6 pulses", dut_ov_cnt, MP);
    bubble(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
